// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for an RV32I datapath: fetch, decode, execute,
// memory access and write-back, with ack-timeout detection and a retire counter.
module core_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_i,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             load_i,
  input  logic             store_i,
  input  logic             reg_write_i,
  output logic             imem_req,
  output logic             ir_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_en,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
  localparam bit          TO_EN   = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_wait_cnt;
  logic             r_ld;
  logic             r_st;
  logic             r_rw;
  logic [CNT_W-1:0] r_instret;
  logic             w_timeout;

  assign w_timeout = TO_EN && (r_wait_cnt == TO_LAST);
  assign instret   = r_instret;
  assign state_o   = r_state;

  always_comb begin
    w_next      = r_state;
    imem_req    = 1'b0;
    ir_en       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_en       = 1'b0;
    busy        = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      S_HALT: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        // An ack on the last allowed wait cycle still completes the fetch.
        if (imem_ack) begin
          ir_en  = 1'b1;
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_DECODE: begin
        busy   = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        busy   = 1'b1;
        w_next = (r_ld || r_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = r_st;
        busy     = 1'b1;
        if (dmem_ack) w_next = S_WB;
        else if (w_timeout) w_next = S_ERR;
      end
      S_WB: begin
        // A combined load+store behaves as a store: no register write.
        rf_we  = r_rw & ~r_st;
        pc_en  = 1'b1;
        busy   = 1'b1;
        w_next = halt_i ? S_HALT : S_FETCH;
      end
      S_ERR: begin
        timeout_err = 1'b1;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_HALT;
      r_wait_cnt <= 32'd0;
      r_ld       <= 1'b0;
      r_st       <= 1'b0;
      r_rw       <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait_cnt <= 32'd0;
      end else if (r_state == S_FETCH || r_state == S_MEM) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
      if (r_state == S_DECODE) begin
        r_ld <= load_i;
        r_st <= store_i;
        r_rw <= reg_write_i;
      end
      if (r_state == S_WB) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a driver plays memory/decoder and queues
// per-instruction expectations; a monitor checks each retirement against them.
module tb_core_sequencer;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             halt_i = 1'b0;
  logic             imem_ack = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             load_i = 1'b0;
  logic             store_i = 1'b0;
  logic             reg_write_i = 1'b0;
  logic             imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, busy, timeout_err;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state_o;

  core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_i(halt_i),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .load_i(load_i),
    .store_i(store_i), .reg_write_i(reg_write_i),
    .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_en(pc_en), .busy(busy), .timeout_err(timeout_err),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               lat;
    int               dreq;
    int               dwe;
    int               rfwe;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  int               n_chk = 0;
  int               n_pass = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: per-instruction activity counted from FETCH entry, checked at retire.
  bit prev_ireq = 1'b0;
  int lat = 0, dreq_n = 0, dwe_n = 0, rfwe_n = 0, ir_n = 0, busy_n = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (imem_req && !prev_ireq) begin
      lat = 0; dreq_n = 0; dwe_n = 0; rfwe_n = 0; ir_n = 0; busy_n = 0;
    end
    prev_ireq = imem_req;
    lat++;
    if (dmem_req) dreq_n++;
    if (dmem_we) dwe_n++;
    if (rf_we) rfwe_n++;
    if (ir_en) ir_n++;
    if (busy) busy_n++;
    if (pc_en) begin
      chk("sb_pending", longint'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("latency", lat, e.lat);
        chk("dmem_req_cycles", dreq_n, e.dreq);
        chk("dmem_we_cycles", dwe_n, e.dwe);
        chk("rf_we_at_wb", longint'(rf_we), e.rfwe);
        chk("rf_we_pulses", rfwe_n, e.rfwe);
        chk("ir_en_pulses", ir_n, 1);
        chk("busy_cycles", busy_n, e.lat);
        chk("instret_at_wb", longint'(instret), longint'(e.cnt));
      end
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge while the DUT sits in its first FETCH cycle.
  task automatic run_instr(input int iw, input int dw, input bit ld, input bit st,
                           input bit rw, input bit hlt);
    exp_t e;
    e.lat  = 4 + iw + ((ld || st) ? dw + 1 : 0);
    e.dreq = (ld || st) ? dw + 1 : 0;
    e.dwe  = st ? e.dreq : 0;
    e.rfwe = (rw && !st) ? 1 : 0;
    e.cnt  = model_cnt;
    model_cnt = model_cnt + 1;
    exp_q.push_back(e);
    repeat (iw) begin
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    dmem_ack = 1'b0; imem_ack = 1'b1;
    load_i = ld; store_i = st; reg_write_i = rw;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    load_i = 1'($urandom_range(0, 1)); store_i = 1'($urandom_range(0, 1));
    reg_write_i = 1'($urandom_range(0, 1));
    imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (ld || st) begin
      repeat (dw) begin
        imem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      imem_ack = 1'b0; dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    halt_i = hlt;
    @(negedge clk);
    halt_i = 1'b0;
  endtask

  task automatic check_halted(input string nm);
    #1;
    chk({nm, "_state"}, longint'(state_o), 0);
    chk({nm, "_instret"}, longint'(instret), longint'(model_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, iw, dw, kind, cnt;
    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", longint'(state_o), 0);
    chk("rst_outputs", longint'({imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, busy, timeout_err}), 0);
    chk("rst_instret", longint'(instret), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("idle_state", longint'(state_o), 0);

    // Directed: ALU, load with 3 wait cycles, store
    @(negedge clk);
    start_pulse(); run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b1); check_halted("alu");
    start_pulse(); run_instr(0, 3, 1'b1, 1'b0, 1'b1, 1'b1); check_halted("load");
    start_pulse(); run_instr(1, 0, 1'b0, 1'b1, 1'b1, 1'b1); check_halted("store");

    // Randomized programs
    for (int p = 0; p < 6; p++) begin
      n = int'($urandom_range(1, 6));
      @(negedge clk);
      start_pulse();
      for (int i = 0; i < n; i++) begin
        iw   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 2));
        dw   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 2));
        kind = int'($urandom_range(0, 3));
        run_instr(iw, dw, kind == 1 || kind == 3, kind == 2 || kind == 3,
                  1'($urandom_range(0, 1)), i == n - 1);
      end
      check_halted("rand_prog");
    end

    // Reset in the middle of a load access
    @(negedge clk);
    start_pulse();
    imem_ack = 1'b1; load_i = 1'b1; reg_write_i = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midmem_rst_state", longint'(state_o), 0);
    chk("midmem_rst_dmem_req", longint'(dmem_req), 0);
    chk("midmem_rst_instret", longint'(instret), 0);
    chk("midmem_rst_strobes", longint'({rf_we, pc_en, busy}), 0);
    model_cnt = '0;
    @(negedge clk);
    rst = 1'b1; load_i = 1'b0; reg_write_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("post_rst_idle", longint'(state_o), 0);

    // Fetch timeout: imem_ack never arrives
    @(negedge clk);
    start_pulse();
    cnt = 0;
    for (int k = 0; k < 40 && state_o != 3'd6; k++) begin
      if (imem_req) cnt++;
      @(negedge clk);
    end
    #1;
    chk("timeout_fetch_cycles", cnt, TIMEOUT);
    chk("err_state", longint'(state_o), 6);
    chk("err_flags", longint'({timeout_err, busy, imem_req}), 4);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("err_sticky_state", longint'(state_o), 6);
    chk("err_sticky_flag", longint'(timeout_err), 1);
    rst = 1'b0;
    #1;
    chk("err_cleared", longint'({timeout_err, state_o}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back, acks on the last allowed wait cycle
    @(negedge clk);
    start_pulse();
    run_instr(15, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(0, 15, 1'b1, 1'b0, 1'b1, 1'b0);
    run_instr(2, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_halted("b2b");
    chk("b2b_instret3", longint'(instret), 3);
    chk("b2b_no_err", longint'(timeout_err), 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
